// File: rtl/lif_setup_pkg.sv
// Shared op-codes, FSM states and sizing helper for the LIF setup/execute driver.
package lif_setup_pkg;

    localparam logic [2:0] OP_INPUTS    = 3'b000;
    localparam logic [2:0] OP_WEIGHTS   = 3'b001;
    localparam logic [2:0] OP_THRESHOLD = 3'b010;
    localparam logic [2:0] OP_BIAS      = 3'b011;
    localparam logic [2:0] OP_SHIFT     = 3'b100;
    localparam logic [2:0] OP_ILLEGAL   = 3'b101;
    localparam logic [2:0] OP_BATCHNORM = 3'b110;
    localparam logic [2:0] OP_RUN       = 3'b111;

    // Control code driven whenever no field is being written; rewrites the shift field.
    localparam logic [2:0] CTRL_IDLE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RUN,
        ST_RESP
    } state_t;

    function automatic int vec_bytes(input int n_stages);
        int inputs;
        inputs = 1 << n_stages;
        return (inputs / 8 > 1) ? inputs / 8 : 1;
    endfunction

endpackage

// File: rtl/lif_byte_serializer.sv
// Loads up to MAX_BYTES bytes and presents them MSB-first, one byte per shift.
module lif_byte_serializer #(
    parameter int MAX_BYTES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic                           shift,
    input  logic [MAX_BYTES*8-1:0]         load_data,
    input  logic [$clog2(MAX_BYTES+1)-1:0] load_len,
    output logic [7:0]                     byte_out,
    output logic                           last
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    logic [MAX_BYTES*8-1:0] shreg;
    logic [LEN_W-1:0]       left;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            left  <= '0;
        end else if (load) begin
            // Left-align so the most significant loaded byte sits in the output slot.
            shreg <= load_data << (8 * (MAX_BYTES - int'(load_len)));
            left  <= load_len;
        end else if (shift && left != '0) begin
            shreg <= shreg << 8;
            left  <= left - 1'b1;
        end
    end

    assign byte_out = shreg[MAX_BYTES*8-1 -: 8];
    assign last     = (left == LEN_W'(1));

endmodule

// File: rtl/lif_setup_driver.sv
// Host-side driver: serialises field writes onto the neuron setup bus and runs
// execute windows while counting LIF/PWM spikes.
module lif_setup_driver
    import lif_setup_pkg::*;
#(
    parameter int N_STAGES = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [31:0]         cmd_data,
    output logic [7:0]          data_out,
    output logic [2:0]          setup_control,
    output logic                setup_sync,
    output logic                execute,
    input  logic                spike_lif,
    input  logic                spike_pwm,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [CNT_BITS-1:0] rsp_lif_count,
    output logic [CNT_BITS-1:0] rsp_pwm_count
);

    localparam int VEC_BYTES = vec_bytes(N_STAGES);
    localparam int VEC_W     = VEC_BYTES * 8;
    localparam int LEN_W     = $clog2(VEC_BYTES + 1);

    state_t              state;
    logic [CNT_BITS-1:0] run_left;
    logic                exec_d;
    logic [2:0]          shadow_shift;
    logic [VEC_W-1:0]    vec_data;
    logic [VEC_W-1:0]    load_data;
    logic [LEN_W-1:0]    load_len;
    logic                load;
    logic [7:0]          ser_byte;
    logic                ser_last;

    // Vector fields wider than the command word are zero-extended.
    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_vec
            if (gi < 32) begin : g_bit
                assign vec_data[gi] = cmd_data[gi];
            end else begin : g_pad
                assign vec_data[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        load_data = VEC_W'(cmd_data[7:0]);
        load_len  = LEN_W'(1);
        if (cmd_op == OP_INPUTS || cmd_op == OP_WEIGHTS) begin
            load_data = vec_data;
            load_len  = LEN_W'(VEC_BYTES);
        end
    end

    assign load = (state == ST_IDLE) && cmd_valid &&
                  (cmd_op != OP_RUN) && (cmd_op != OP_ILLEGAL);

    lif_byte_serializer #(
        .MAX_BYTES (VEC_BYTES)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (state == ST_SEND),
        .load_data (load_data),
        .load_len  (load_len),
        .byte_out  (ser_byte),
        .last      (ser_last)
    );

    assign data_out = (state == ST_SEND) ? ser_byte : {5'b0, shadow_shift};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            execute       <= 1'b0;
            exec_d        <= 1'b0;
            setup_sync    <= 1'b0;
            setup_control <= CTRL_IDLE;
            rsp_valid     <= 1'b0;
            rsp_lif_count <= '0;
            rsp_pwm_count <= '0;
            shadow_shift  <= 3'b000;
            run_left      <= '0;
        end else begin
            exec_d     <= execute;
            setup_sync <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_RUN) begin
                            rsp_lif_count <= '0;
                            rsp_pwm_count <= '0;
                            run_left      <= cmd_data[CNT_BITS-1:0];
                            cmd_ready     <= 1'b0;
                            if (cmd_data[CNT_BITS-1:0] == '0) begin
                                state     <= ST_RESP;
                                rsp_valid <= 1'b1;
                            end else begin
                                state   <= ST_RUN;
                                execute <= 1'b1;
                            end
                        end else if (cmd_op != OP_ILLEGAL) begin
                            state         <= ST_SEND;
                            cmd_ready     <= 1'b0;
                            setup_sync    <= 1'b1;
                            setup_control <= cmd_op;
                            if (cmd_op == OP_SHIFT) begin
                                shadow_shift <= cmd_data[2:0];
                            end
                        end
                    end
                end
                ST_SEND: begin
                    if (ser_last) begin
                        state         <= ST_IDLE;
                        cmd_ready     <= 1'b1;
                        setup_control <= CTRL_IDLE;
                    end
                end
                ST_RUN: begin
                    if (execute) begin
                        run_left <= run_left - 1'b1;
                        if (run_left == CNT_BITS'(1)) begin
                            execute <= 1'b0;
                        end
                    end
                    // Spikes lag execute by one cycle, so sample while the delayed copy is high.
                    if (exec_d) begin
                        if (spike_lif && rsp_lif_count != '1) begin
                            rsp_lif_count <= rsp_lif_count + 1'b1;
                        end
                        if (spike_pwm && rsp_pwm_count != '1) begin
                            rsp_pwm_count <= rsp_pwm_count + 1'b1;
                        end
                        if (!execute) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_setup_driver.sv
// Directed bench for lif_setup_driver: timeline model checked every cycle plus literal pins.
module tb_lif_setup_driver;

    localparam int CNT_BITS = 16;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic [2:0]          cmd_op = 3'b000;
    logic [31:0]         cmd_data = 32'h0;
    logic                spike_lif = 1'b0;
    logic                spike_pwm = 1'b0;
    logic                rsp_ready = 1'b0;
    logic                cmd_ready;
    logic [7:0]          data_out;
    logic [2:0]          setup_control;
    logic                setup_sync;
    logic                execute;
    logic                rsp_valid;
    logic [CNT_BITS-1:0] rsp_lif_count;
    logic [CNT_BITS-1:0] rsp_pwm_count;

    lif_setup_driver #(
        .N_STAGES (5),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .data_out      (data_out),
        .setup_control (setup_control),
        .setup_sync    (setup_sync),
        .execute       (execute),
        .spike_lif     (spike_lif),
        .spike_pwm     (spike_pwm),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_lif_count (rsp_lif_count),
        .rsp_pwm_count (rsp_pwm_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: on acceptance at cycle T a field write occupies cycles T..T+n-1,
    // a RUN n drives execute in T..T+n-1, samples spikes in T+1..T+n, answers from T+n+1.
    bit         model_valid = 0;
    int         send_t = 0, send_n = 0;
    logic [2:0] send_op = 3'b000;
    logic [7:0] send_b [4];
    bit         run_act = 0;
    int         run_t = 0, run_n = 0;
    bit         rsp_pend = 0;
    int         rsp_from = 0;
    int         m_lif = 0, m_pwm = 0;
    logic [2:0] m_shadow = 3'b000;
    bit         in_send;
    logic       e_ready, e_exec, e_sync, e_rsp;
    logic [7:0] e_data;
    logic [2:0] e_ctrl;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            send_n = 0; run_act = 0; rsp_pend = 0;
            m_lif = 0; m_pwm = 0; m_shadow = 3'b000;
            model_valid = 1;
        end else if (model_valid) begin
            if (run_act && cyc >= run_t + 2 && cyc <= run_t + run_n + 1) begin
                if (spike_lif && m_lif < CNT_MAX) m_lif++;
                if (spike_pwm && m_pwm < CNT_MAX) m_pwm++;
            end
            if (run_act && cyc == run_t + run_n + 1) begin
                run_act = 0; rsp_pend = 1; rsp_from = cyc;
            end
            if (rsp_pend && cyc - 1 >= rsp_from && rsp_ready) rsp_pend = 0;
            if (cmd_valid && e_ready) begin
                if (cmd_op == 3'b111) begin
                    m_lif = 0; m_pwm = 0;
                    run_t = cyc; run_n = int'(cmd_data[CNT_BITS-1:0]);
                    if (run_n == 0) begin rsp_pend = 1; rsp_from = cyc; end
                    else run_act = 1;
                end else if (cmd_op != 3'b101) begin
                    send_t = cyc; send_op = cmd_op;
                    send_n = (cmd_op == 3'b000 || cmd_op == 3'b001) ? 4 : 1;
                    for (int k = 0; k < 4; k++)
                        send_b[k] = (send_n == 4) ? 8'(cmd_data >> (24 - 8 * k)) : cmd_data[7:0];
                    if (cmd_op == 3'b100) m_shadow = cmd_data[2:0];
                end
            end
        end
        in_send = (send_n > 0) && (cyc < send_t + send_n);
        e_exec  = run_act && (cyc <= run_t + run_n - 1);
        e_ready = !in_send && !run_act && !rsp_pend;
        e_rsp   = rsp_pend;
        e_data  = in_send ? send_b[cyc - send_t] : {5'b0, m_shadow};
        e_ctrl  = in_send ? send_op : 3'b100;
        e_sync  = in_send && (cyc == send_t);
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("execute", 32'(execute), 32'(e_exec));
            chk("setup_sync", 32'(setup_sync), 32'(e_sync));
            chk("data_out", 32'(data_out), 32'(e_data));
            chk("setup_control", 32'(setup_control), 32'(e_ctrl));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_rsp) begin
                chk("rsp_lif_count", 32'(rsp_lif_count), 32'(m_lif));
                chk("rsp_pwm_count", 32'(rsp_pwm_count), 32'(m_pwm));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one step past the accepting edge, i.e. inside the first busy cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] d);
        int waited;
        waited = 0;
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && waited < 200) begin
            step(1);
            waited++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
        step(1);
        cmd_valid = 1'b0;
        $display("[TB] cmd op=%0d data=0x%08h accepted, cycle %0d", op, d, cyc);
    endtask

    task automatic wait_rsp();
        int waited;
        waited = 0;
        while (!rsp_valid && waited < 100) begin
            step(1);
            waited++;
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        $display("[TB] rsp lif=%0d pwm=%0d consumed, cycle %0d", rsp_lif_count, rsp_pwm_count, cyc);
    endtask

    int n_exec;

    initial begin
        step(3);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_ctrl", 32'(setup_control), 32'h4);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_lif", 32'(rsp_lif_count), 32'd0);
        rst_n = 1'b1;
        step(5);
        chk("idle_ctrl", 32'(setup_control), 32'h4);
        chk("idle_exec", 32'(execute), 32'd0);

        issue(3'b001, 32'hDEADBEEF);
        chk("w_b0", 32'(data_out), 32'hDE);
        chk("w_ctrl", 32'(setup_control), 32'h1);
        chk("w_sync0", 32'(setup_sync), 32'd1);
        step(1);
        chk("w_b1", 32'(data_out), 32'hAD);
        chk("w_sync1", 32'(setup_sync), 32'd0);
        step(1);
        chk("w_b2", 32'(data_out), 32'hBE);
        step(1);
        chk("w_b3", 32'(data_out), 32'hEF);
        step(1);
        chk("w_done_ctrl", 32'(setup_control), 32'h4);
        chk("w_done_ready", 32'(cmd_ready), 32'd1);

        issue(3'b010, 32'h000001A7);
        chk("thr_byte", 32'(data_out), 32'hA7);
        step(1);

        issue(3'b100, 32'h5);
        chk("shift_beat", 32'(data_out), 32'h05);
        chk("shift_sync", 32'(setup_sync), 32'd1);
        step(4);
        chk("shift_idle", 32'(data_out), 32'h05);

        issue(3'b101, 32'hFF);
        chk("illegal_ready", 32'(cmd_ready), 32'd1);
        chk("illegal_data", 32'(data_out), 32'h05);

        issue(3'b110, 32'h80);
        step(2);

        spike_lif = 1'b1;
        issue(3'b111, 32'd10);
        n_exec = 0;
        for (int i = 0; i < 30 && !rsp_valid; i++) begin
            if (execute) n_exec++;
            step(1);
        end
        chk("run10_exec_cycles", 32'(n_exec), 32'd10);
        chk("run10_lif", 32'(rsp_lif_count), 32'd10);
        chk("run10_pwm", 32'(rsp_pwm_count), 32'd0);
        spike_lif = 1'b0;
        take_rsp();

        // Spike in the first execute cycle falls outside the window; one in the tail cycle counts.
        issue(3'b111, 32'd4);
        spike_lif = 1'b1;
        step(1);
        spike_lif = 1'b0;
        step(3);
        spike_pwm = 1'b1;
        step(1);
        spike_pwm = 1'b0;
        wait_rsp();
        chk("run4_lif", 32'(rsp_lif_count), 32'd0);
        chk("run4_pwm", 32'(rsp_pwm_count), 32'd1);
        take_rsp();

        issue(3'b111, 32'd0);
        chk("run0_rsp", 32'(rsp_valid), 32'd1);
        chk("run0_exec", 32'(execute), 32'd0);
        chk("run0_lif", 32'(rsp_lif_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("run0_hold", 32'(rsp_valid), 32'd1);
        end
        take_rsp();

        issue(3'b000, 32'h11223344);
        step(2);
        chk("in_b2", 32'(data_out), 32'h33);
        rst_n = 1'b0;
        step(1);
        chk("abort_w_ready", 32'(cmd_ready), 32'd1);
        chk("abort_w_data", 32'(data_out), 32'h00);
        chk("abort_w_ctrl", 32'(setup_control), 32'h4);
        rst_n = 1'b1;
        step(2);

        issue(3'b111, 32'd20);
        step(5);
        chk("run20_exec", 32'(execute), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("abort_r_exec", 32'(execute), 32'd0);
        chk("abort_r_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        step(3);

        issue(3'b000, 32'hCAFEF00D);
        chk("in2_b0", 32'(data_out), 32'hCA);
        step(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
